// File: rtl/cpu_common_pkg.sv
// Shared CPU encodings: fetch operations, ALU functions, opcodes and instruction types.
// Also holds the decoded opcode class used between decode and the sequencer.
package cpu_common;

    typedef enum logic [1:0] {
        FETCH_NOP    = 2'd0,
        FETCH_INC_PC = 2'd1,
        FETCH_JUMP   = 2'd2
    } fetch_operation_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_MOV = 3'd5
    } alu_op_t;

    typedef enum logic [2:0] {
        ClsNop,
        ClsHalt,
        ClsJmp,
        ClsBz,
        ClsAlu,
        ClsMov,
        ClsLoad,
        ClsStore
    } op_class_t;

    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_HALT  = 6'h01;
    localparam logic [5:0] OP_JMP   = 6'h02;
    localparam logic [5:0] OP_BZ    = 6'h03;
    localparam logic [5:0] OP_ADD   = 6'h08;
    localparam logic [5:0] OP_SUB   = 6'h09;
    localparam logic [5:0] OP_AND   = 6'h0A;
    localparam logic [5:0] OP_OR    = 6'h0B;
    localparam logic [5:0] OP_XOR   = 6'h0C;
    localparam logic [5:0] OP_MOV   = 6'h0D;
    localparam logic [5:0] OP_LOAD  = 6'h10;
    localparam logic [5:0] OP_STORE = 6'h11;

    localparam logic [1:0] TYPE_SHORT = 2'b00;
    localparam logic [1:0] TYPE_RSV   = 2'b01;
    localparam logic [1:0] TYPE_IMM   = 2'b10;
    localparam logic [1:0] TYPE_REG   = 2'b11;

    // ALU opcodes 0x08..0x0D map directly onto alu_op_t by their low three bits.
    function automatic alu_op_t alu_op_from_opcode(input logic [5:0] opcode);
        return alu_op_t'(opcode[2:0]);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decode: ir -> opcode class, ALU function and register fields.
// Illegal opcode/type combinations collapse to ClsNop.
module control_decode
    import cpu_common::*;
(
    input  logic [15:0] i_ir,
    output op_class_t   o_cls,
    output alu_op_t     o_alu_op,
    output logic        o_alu_b_sel,
    output logic [7:0]  o_imm8,
    output logic [2:0]  o_rf_rd,
    output logic [2:0]  o_rf_rs,
    output logic [2:0]  o_rf_waddr
);

    logic [5:0] w_opcode;
    logic [1:0] w_type;
    logic       w_long;
    logic [2:0] w_rd;

    assign w_opcode = i_ir[7:2];
    assign w_type   = i_ir[1:0];
    assign w_long   = i_ir[1];

    // Immediate form always targets r0; only register form carries rd/rs.
    assign w_rd        = (w_type == TYPE_REG) ? i_ir[10:8] : 3'd0;
    assign o_rf_rs     = (w_type == TYPE_REG) ? i_ir[13:11] : 3'd0;
    assign o_rf_rd     = w_rd;
    assign o_rf_waddr  = w_rd;
    assign o_imm8      = i_ir[15:8];
    assign o_alu_b_sel = (w_type == TYPE_IMM);

    always_comb begin
        o_cls    = ClsNop;
        o_alu_op = ALU_ADD;
        case (w_opcode)
            OP_HALT: o_cls = ClsHalt;
            OP_JMP:  o_cls = ClsJmp;
            OP_BZ:   o_cls = ClsBz;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                if (w_long) begin
                    o_cls    = ClsAlu;
                    o_alu_op = alu_op_from_opcode(w_opcode);
                end
            end
            OP_MOV: begin
                if (w_long) begin
                    o_cls    = ClsMov;
                    o_alu_op = ALU_MOV;
                end
            end
            OP_LOAD:  if (w_long) o_cls = ClsLoad;
            OP_STORE: if (w_long) o_cls = ClsStore;
            default:  o_cls = ClsNop;
        endcase
    end

endmodule

// File: rtl/control.sv
// CPU sequencer: latches the fetched instruction, drives datapath strobes for one or two
// cycles, then issues exactly one fetch operation to advance or redirect the PC.
module control
    import cpu_common::*;
(
    input  logic             clk,
    input  logic             rst_async_n,
    input  logic             fetch_complete,
    input  logic [15:0]      inst,
    output fetch_operation_t fetch_operation,
    input  logic             flag_z,
    output alu_op_t          alu_op,
    output logic             alu_b_sel,
    output logic [7:0]       imm8,
    output logic [2:0]       rf_rd,
    output logic [2:0]       rf_rs,
    output logic             rf_we,
    output logic [2:0]       rf_waddr,
    output logic             rf_wsel,
    output logic             flags_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             halted
);

    typedef enum logic [2:0] {StWait, StExec, StMemwb, StAdv, StHalt} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_ir;
    op_class_t   w_cls;

    control_decode u_decode (
        .i_ir        (r_ir),
        .o_cls       (w_cls),
        .o_alu_op    (alu_op),
        .o_alu_b_sel (alu_b_sel),
        .o_imm8      (imm8),
        .o_rf_rd     (rf_rd),
        .o_rf_rs     (rf_rs),
        .o_rf_waddr  (rf_waddr)
    );

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_state <= StWait;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            if (r_state == StWait && fetch_complete) r_ir <= inst;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        fetch_operation = FETCH_NOP;
        rf_we           = 1'b0;
        rf_wsel         = 1'b0;
        flags_we        = 1'b0;
        mem_re          = 1'b0;
        mem_we          = 1'b0;
        halted          = 1'b0;
        unique case (r_state)
            StWait: if (fetch_complete) w_state_next = StExec;
            StExec: begin
                w_state_next = StAdv;
                case (w_cls)
                    ClsAlu: begin
                        rf_we    = 1'b1;
                        flags_we = 1'b1;
                    end
                    ClsMov:   rf_we = 1'b1;
                    ClsLoad: begin
                        mem_re       = 1'b1;
                        w_state_next = StMemwb;
                    end
                    ClsStore: mem_we = 1'b1;
                    ClsHalt:  w_state_next = StHalt;
                    default:  w_state_next = StAdv;
                endcase
            end
            StMemwb: begin
                rf_we        = 1'b1;
                rf_wsel      = 1'b1;
                w_state_next = StAdv;
            end
            // flag_z is taken live here so a BZ sees the flags left by the prior instruction.
            StAdv: begin
                if (w_cls == ClsJmp || (w_cls == ClsBz && flag_z)) fetch_operation = FETCH_JUMP;
                else fetch_operation = FETCH_INC_PC;
                w_state_next = StWait;
            end
            StHalt: halted = 1'b1;
            default: w_state_next = StWait;
        endcase
    end

endmodule

// File: tb/tb_control.sv
// Directed bench for the control sequencer: one linear stimulus sequence with
// hand-computed expectations checked by immediate assertions.
module tb_control;
    import cpu_common::*;

    logic             clk;
    logic             rst_async_n;
    logic             fetch_complete;
    logic [15:0]      inst;
    fetch_operation_t fetch_operation;
    logic             flag_z;
    alu_op_t          alu_op;
    logic             alu_b_sel;
    logic [7:0]       imm8;
    logic [2:0]       rf_rd;
    logic [2:0]       rf_rs;
    logic             rf_we;
    logic [2:0]       rf_waddr;
    logic             rf_wsel;
    logic             flags_we;
    logic             mem_re;
    logic             mem_we;
    logic             halted;

    int errors = 0;
    int checks = 0;

    control dut (
        .clk             (clk),
        .rst_async_n     (rst_async_n),
        .fetch_complete  (fetch_complete),
        .inst            (inst),
        .fetch_operation (fetch_operation),
        .flag_z          (flag_z),
        .alu_op          (alu_op),
        .alu_b_sel       (alu_b_sel),
        .imm8            (imm8),
        .rf_rd           (rf_rd),
        .rf_rs           (rf_rs),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wsel         (rf_wsel),
        .flags_we        (flags_we),
        .mem_re          (mem_re),
        .mem_we          (mem_we),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobes packed as {rf_we, flags_we, mem_re, mem_we}.
    function automatic logic [15:0] strobes();
        return {12'd0, rf_we, flags_we, mem_re, mem_we};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in WAIT and advance into EXEC.
    task automatic issue(input logic [15:0] i);
        inst           = i;
        fetch_complete = 1'b1;
        step();
        fetch_complete = 1'b0;
    endtask

    initial begin
        rst_async_n    = 1'b0;
        fetch_complete = 1'b0;
        inst           = 16'h0000;
        flag_z         = 1'b0;
        #2;
        chk("rst_fetch", 16'(fetch_operation), 16'(FETCH_NOP));
        chk("rst_strobes", strobes(), 16'h0);
        chk("rst_halted", 16'(halted), 16'h0);
        chk("rst_imm8", 16'(imm8), 16'h0);
        @(negedge clk);
        rst_async_n = 1'b1;
        step();
        chk("wait_idle_fetch", 16'(fetch_operation), 16'(FETCH_NOP));

        // ADD r0,#5
        inst           = 16'h0522;
        fetch_complete = 1'b1;
        #1;
        chk("add_wait_strobes", strobes(), 16'h0);
        step();
        fetch_complete = 1'b0;
        chk("add_exec_aluop", 16'(alu_op), 16'(ALU_ADD));
        chk("add_exec_bsel", 16'(alu_b_sel), 16'h1);
        chk("add_exec_imm8", 16'(imm8), 16'h05);
        chk("add_exec_waddr", 16'(rf_waddr), 16'h0);
        chk("add_exec_strobes", strobes(), 16'b1100);
        chk("add_exec_fetch", 16'(fetch_operation), 16'(FETCH_NOP));
        step();
        chk("add_adv_strobes", strobes(), 16'h0);
        chk("add_adv_fetch", 16'(fetch_operation), 16'(FETCH_INC_PC));
        step();
        chk("add_wait_fetch", 16'(fetch_operation), 16'(FETCH_NOP));

        // LOAD r3
        issue(16'h0343);
        chk("ld_exec_strobes", strobes(), 16'b0010);
        chk("ld_exec_fetch", 16'(fetch_operation), 16'(FETCH_NOP));
        step();
        chk("ld_memwb_strobes", strobes(), 16'b1000);
        chk("ld_memwb_wsel", 16'(rf_wsel), 16'h1);
        chk("ld_memwb_waddr", 16'(rf_waddr), 16'h3);
        chk("ld_memwb_fetch", 16'(fetch_operation), 16'(FETCH_NOP));
        step();
        chk("ld_adv_fetch", 16'(fetch_operation), 16'(FETCH_INC_PC));
        chk("ld_adv_strobes", strobes(), 16'h0);
        step();
        chk("ld_wait_fetch", 16'(fetch_operation), 16'(FETCH_NOP));

        // STORE r5
        issue(16'h0547);
        chk("st_exec_strobes", strobes(), 16'b0001);
        chk("st_exec_rd", 16'(rf_rd), 16'h5);
        step();
        chk("st_adv_fetch", 16'(fetch_operation), 16'(FETCH_INC_PC));
        step();

        // MOV r2,r3
        issue(16'h1A37);
        chk("mov_exec_strobes", strobes(), 16'b1000);
        chk("mov_exec_aluop", 16'(alu_op), 16'(ALU_MOV));
        chk("mov_exec_bsel", 16'(alu_b_sel), 16'h0);
        chk("mov_exec_rs", 16'(rf_rs), 16'h3);
        chk("mov_exec_waddr", 16'(rf_waddr), 16'h2);
        step();
        chk("mov_adv_fetch", 16'(fetch_operation), 16'(FETCH_INC_PC));
        step();

        // JMP
        issue(16'h0008);
        chk("jmp_exec_strobes", strobes(), 16'h0);
        step();
        chk("jmp_adv_fetch", 16'(fetch_operation), 16'(FETCH_JUMP));
        step();

        // BZ taken, then not taken
        flag_z = 1'b1;
        issue(16'h000C);
        chk("bz1_exec_strobes", strobes(), 16'h0);
        step();
        chk("bz1_adv_fetch", 16'(fetch_operation), 16'(FETCH_JUMP));
        step();
        flag_z = 1'b0;
        issue(16'h000C);
        step();
        chk("bz0_adv_fetch", 16'(fetch_operation), 16'(FETCH_INC_PC));
        step();

        // Short-type ADD and undefined opcode behave as NOP
        issue(16'h0020);
        chk("ill_add_strobes", strobes(), 16'h0);
        step();
        chk("ill_add_fetch", 16'(fetch_operation), 16'(FETCH_INC_PC));
        step();
        issue(16'h00FC);
        chk("undef_strobes", strobes(), 16'h0);
        step();
        chk("undef_fetch", 16'(fetch_operation), 16'(FETCH_INC_PC));
        step();

        // Reset during MEMWB of a LOAD kills the writeback immediately
        issue(16'h0343);
        step();
        chk("ldrst_memwb_we", 16'(rf_we), 16'h1);
        rst_async_n = 1'b0;
        #1;
        chk("ldrst_we_now", 16'(rf_we), 16'h0);
        chk("ldrst_imm8", 16'(imm8), 16'h0);
        #2;
        rst_async_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("postrst_strobes", strobes(), 16'h0);
            chk("postrst_fetch", 16'(fetch_operation), 16'(FETCH_NOP));
        end

        // HALT holds until reset
        issue(16'h0004);
        chk("halt_exec_halted", 16'(halted), 16'h0);
        for (int i = 0; i < 20; i++) begin
            step();
            fetch_complete = i[0];
            chk("halt_halted", 16'(halted), 16'h1);
            chk("halt_fetch", 16'(fetch_operation), 16'(FETCH_NOP));
            chk("halt_strobes", strobes(), 16'h0);
        end
        rst_async_n = 1'b0;
        #1;
        chk("halt_rst_halted", 16'(halted), 16'h0);
        fetch_complete = 1'b0;
        #2;
        rst_async_n = 1'b1;
        step();
        chk("halt_rst_fetch", 16'(fetch_operation), 16'(FETCH_NOP));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
